// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR into the sequencer, datapath controls out.
// Optional Instr_Count port appears only when CU_INSTR_COUNT_EN is defined.
interface control_unit_if #(
    parameter int instr_bits     = 16,
    parameter int reg_addr_width = 4,
    parameter int d_addr_width   = 8,
    parameter int alu_sel_bits   = 3
);
    logic [instr_bits-1:0]     IR;
    logic                      PC_Clr;
    logic                      PC_Up;
    logic                      IR_Ld;
    logic [d_addr_width-1:0]   D_Addr;
    logic                      D_Wr;
    logic                      RF_s;
    logic [reg_addr_width-1:0] RF_W_Addr;
    logic                      RF_W_en;
    logic [reg_addr_width-1:0] RF_Ra_Addr;
    logic [reg_addr_width-1:0] RF_Rb_Addr;
    logic [alu_sel_bits-1:0]   ALU_s0;
    logic [3:0]                OutState;
`ifdef CU_INSTR_COUNT_EN
    logic [15:0]               Instr_Count;
`endif

    modport master (
        input  IR,
        output PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
        output RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState
`ifdef CU_INSTR_COUNT_EN
        , output Instr_Count
`endif
    );

    modport slave (
        output IR,
        input  PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
        input  RF_Ra_Addr, RF_Rb_Addr, ALU_s0, OutState
`ifdef CU_INSTR_COUNT_EN
        , input Instr_Count
`endif
    );
endinterface

// File: rtl/control_unit.sv
// Moore fetch/decode/execute sequencer; outputs depend on state plus IR fields only.
// Optional macro CU_INSTR_COUNT_EN adds a 16-bit decoded-instruction counter.
module control_unit #(
    parameter int instr_bits     = 16,
    parameter int reg_addr_width = 4,
    parameter int d_addr_width   = 8,
    parameter int alu_sel_bits   = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    control_unit_if.master bus
);
    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOADA  = 4'd4;
    localparam logic [3:0] S_LOADB  = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [3:0] opcode;

    assign opcode = bus.IR[instr_bits-1 -: 4];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'b0001: state_nxt = S_STORE;
                    4'b0010: state_nxt = S_LOADA;
                    4'b0011: state_nxt = S_ADD;
                    4'b0100: state_nxt = S_SUB;
                    4'b0101: state_nxt = S_HALT;
                    default: state_nxt = S_NOOP;
                endcase
            end
            S_NOOP:   state_nxt = S_FETCH;
            S_LOADA:  state_nxt = S_LOADB;
            S_LOADB:  state_nxt = S_FETCH;
            S_STORE:  state_nxt = S_FETCH;
            S_ADD:    state_nxt = S_FETCH;
            S_SUB:    state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        bus.PC_Clr     = 1'b0;
        bus.PC_Up      = 1'b0;
        bus.IR_Ld      = 1'b0;
        bus.D_Addr     = '0;
        bus.D_Wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_Addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_Addr = '0;
        bus.RF_Rb_Addr = '0;
        bus.ALU_s0     = '0;
        bus.OutState   = state;
        case (state)
            S_INIT:  bus.PC_Clr = 1'b1;
            S_FETCH: begin
                bus.PC_Up = 1'b1;
                bus.IR_Ld = 1'b1;
            end
            // LoadA holds the RAM address one extra cycle so sync-read data is valid in LoadB.
            S_LOADA, S_LOADB: begin
                bus.D_Addr    = bus.IR[11:4];
                bus.RF_s      = 1'b1;
                bus.RF_W_Addr = bus.IR[3:0];
                bus.RF_W_en   = (state == S_LOADB);
            end
            S_STORE: begin
                bus.D_Addr     = bus.IR[7:0];
                bus.RF_Ra_Addr = bus.IR[11:8];
                bus.D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_Addr = bus.IR[11:8];
                bus.RF_Rb_Addr = bus.IR[7:4];
                bus.RF_W_Addr  = bus.IR[3:0];
                bus.ALU_s0     = (state == S_ADD) ? 3'd1 : 3'd2;
                bus.RF_W_en    = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CU_INSTR_COUNT_EN
    logic [15:0] instr_cnt;

    // Every decoded instruction leaves Decode exactly once, Halt included.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                  instr_cnt <= 16'd0;
        else if (state == S_DECODE) instr_cnt <= instr_cnt + 16'd1;
    end

    assign bus.Instr_Count = instr_cnt;
`endif
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class, Halt hold and mid-instruction reset.
module tb_control_unit;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;
    logic [32:0] expv;

    control_unit_if bus ();

    control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [32:0] obs();
        return {bus.PC_Clr, bus.PC_Up, bus.IR_Ld, bus.D_Addr, bus.D_Wr, bus.RF_s,
                bus.RF_W_Addr, bus.RF_W_en, bus.RF_Ra_Addr, bus.RF_Rb_Addr,
                bus.ALU_s0, bus.OutState};
    endfunction

    function automatic logic [32:0] mk(input logic pcclr, input logic pcup, input logic irld,
                                       input logic [7:0] da, input logic dwr, input logic rfs,
                                       input logic [3:0] wa, input logic wen,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [2:0] alu, input logic [3:0] st);
        return {pcclr, pcup, irld, da, dwr, rfs, wa, wen, ra, rb, alu, st};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.IR = 16'h0000;
        #1;
        expv = mk(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd0);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL reset_init got %h exp %h", obs(), expv); end
        tick();
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL reset_held got %h exp %h", obs(), expv); end
`ifdef CU_INSTR_COUNT_EN
        n_checks++;
        if (bus.Instr_Count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %h exp 0000", bus.Instr_Count); end
`endif
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        expv = mk(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL first_fetch got %h exp %h", obs(), expv); end
    endtask

    // Entered with the DUT sampled in Fetch; loads IR as the fetch edge would and checks Decode.
    task automatic issue(input logic [15:0] ir, input string nm);
        tick();
        bus.IR = ir;
        expv = mk(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd2);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL %s_decode got %h exp %h", nm, obs(), expv); end
    endtask

    task automatic expect_fetch(input string nm);
        tick();
        expv = mk(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL %s_back_to_fetch got %h exp %h", nm, obs(), expv); end
    endtask

    task automatic test_load();
        issue(16'h2A53, "load");
        tick();
        expv = mk(0,0,0,8'hA5,0,1,4'h3,0,4'h0,4'h0,3'd0,4'd4);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL loada got %h exp %h", obs(), expv); end
        tick();
        expv = mk(0,0,0,8'hA5,0,1,4'h3,1,4'h0,4'h0,3'd0,4'd5);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL loadb got %h exp %h", obs(), expv); end
        expect_fetch("load");
    endtask

    task automatic test_store();
        issue(16'h1C40, "store");
        tick();
        expv = mk(0,0,0,8'h40,1,0,4'h0,0,4'hC,4'h0,3'd0,4'd6);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL store got %h exp %h", obs(), expv); end
        expect_fetch("store");
    endtask

    task automatic test_add_sub();
        issue(16'h3127, "add");
        tick();
        expv = mk(0,0,0,8'h00,0,0,4'h7,1,4'h1,4'h2,3'd1,4'd7);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL add got %h exp %h", obs(), expv); end
        expect_fetch("add");
        issue(16'h4127, "sub");
        tick();
        expv = mk(0,0,0,8'h00,0,0,4'h7,1,4'h1,4'h2,3'd2,4'd8);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL sub got %h exp %h", obs(), expv); end
        expect_fetch("sub");
    endtask

    task automatic test_noop();
        logic [15:0] irs [3];
        irs[0] = 16'hF123;
        irs[1] = 16'h6FFF;
        irs[2] = 16'h0ABC;
        for (int i = 0; i < 3; i++) begin
            issue(irs[i], "noop");
            tick();
            expv = mk(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd3);
            n_checks++;
            if (obs() !== expv) begin n_fail++; $display("FAIL noop_%0d ir %h got %h exp %h", i, irs[i], obs(), expv); end
            expect_fetch("noop");
        end
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        issue(16'h5000, "halt");
        expv = mk(0,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd9);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs() !== expv) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL halt_hold %0d of 20 cycles wrong, last %h exp %h", bad, obs(), expv); end
`ifdef CU_INSTR_COUNT_EN
        // load, store, add, sub, three noops, halt
        n_checks++;
        if (bus.Instr_Count !== 16'd8) begin n_fail++; $display("FAIL halt_count got %0d exp 8", bus.Instr_Count); end
`endif
    endtask

    task automatic test_reset_mid();
        int wen_seen;
        wen_seen = 0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        expv = mk(0,1,1,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd1);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL halt_exit_fetch got %h exp %h", obs(), expv); end
        issue(16'h2A53, "rstmid");
        tick();
        n_checks++;
        if (bus.OutState !== 4'd4) begin n_fail++; $display("FAIL rstmid_in_loada got %0d exp 4", bus.OutState); end
        #2;
        Reset = 1'b1;
        #1;
        expv = mk(1,0,0,8'h00,0,0,4'h0,0,4'h0,4'h0,3'd0,4'd0);
        n_checks++;
        if (obs() !== expv) begin n_fail++; $display("FAIL rstmid_async got %h exp %h", obs(), expv); end
`ifdef CU_INSTR_COUNT_EN
        n_checks++;
        if (bus.Instr_Count !== 16'd0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", bus.Instr_Count); end
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.RF_W_en !== 1'b0) wen_seen++;
        end
        @(negedge Clk);
        Reset = 1'b0;
        tick();
        if (bus.RF_W_en !== 1'b0) wen_seen++;
        n_checks++;
        if (wen_seen != 0) begin n_fail++; $display("FAIL rstmid_no_write got %0d wen cycles exp 0", wen_seen); end
        n_checks++;
        if (bus.OutState !== 4'd1) begin n_fail++; $display("FAIL rstmid_refetch got %0d exp 1", bus.OutState); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_load();
        test_store();
        test_add_sub();
        test_noop();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
